radiant_scaler_input_cond: RTL
==============================

# radiant_scaler_input_cond

Per-channel conditioning stage directly upstream of the RADIANT scaler block. It synchronizes raw, asynchronous trigger/comparator bits into the 50 MHz scaler clock domain and rising-edge detects them. It applies mask, global veto and a programmable per-pulse holdoff, and emits clean single-cycle count pulses that drive the scalers' `scal_i` bus. It also flags dropped edges (missed during holdoff) and stuck-high inputs for diagnostics.

## Interface
Parameters:
- `NUM_CH`, 32, number of channels (1–64)
- `HOLDOFF_BITS`, 8, width of holdoff setting/counter
- `STUCK_BITS`, 16, width of per-channel high-time counter

Ports:
- `clk_i` in 1: 50 MHz scaler clock; all logic in this domain
- `rst_n_i` in 1: reset, asynchronous, active-low
- `trig_i` in NUM_CH: raw asynchronous trigger bits
- `mask_i` in NUM_CH: 1 = channel disabled (quasi-static, clk_i domain)
- `veto_i` in 1: synchronous global veto, 1 = suppress new pulses
- `holdoff_i` in HOLDOFF_BITS: dead cycles after each pulse (quasi-static)
- `clear_i` in 1: synchronous single-cycle clear of sticky `missed_o`
- `pulse_o` out NUM_CH: one-cycle count pulses to scaler `scal_i`
- `missed_o` out NUM_CH: sticky, edge dropped during holdoff
- `stuck_o` out NUM_CH: input continuously high ≥ 2^STUCK_BITS−1 cycles

## Operation
- Per channel: 2-FF synchronizer (`s1`, `s2`), previous-value reg `p`; `edge = s2 & ~p`.
- Channel FSM, two states:
  - ARMED: on `edge & ~mask & ~veto` → assert `pulse_o` next cycle. If `holdoff_i == 0`, stay ARMED; else go HOLD with `cnt <= holdoff_i`.
  - HOLD: `cnt` decrements each cycle. Returns to ARMED on the cycle `cnt == 1` (exactly `holdoff_i` cycles in HOLD). An `edge` in HOLD (unmasked, unvetoed) is dropped and sets `missed_o`.
- `holdoff_i` is sampled only on entry to HOLD; changes mid-hold do not affect the running count.
- Vetoed edges: no pulse, no HOLD entry, no `missed_o`.
- Mask: a masked channel is forced to ARMED with `cnt = 0`; it never pulses and never sets `missed_o`. Stuck monitoring continues while masked.
- Stuck: `hcnt` increments while `s2 == 1` and saturates at all-ones. It resets to 0 when `s2 == 0`. `stuck_o = (hcnt == all-ones)`, so it drops the cycle after `s2` falls. A stuck input yields exactly one pulse (single edge).
- `clear_i` clears all `missed_o`. A clear and a new miss in the same cycle: the set wins.
- An edge arriving on the same cycle the FSM returns to ARMED is accepted: pulse, not miss.

## Timing
- Reset (async assert, sync use after deassert): `s1`, `s2`, `p`, `cnt`, `hcnt` = 0; FSM = ARMED; `pulse_o`, `missed_o`, `stuck_o` = 0.
- Reset mid-operation aborts holdoffs immediately. After release, an input that is already high produces one pulse, because `p = 0` → edge.
- Latency: `trig_i` sampled high at clock edge E0 → `s2` high after E1 → `pulse_o` high for exactly the cycle after E2.
- Minimum pulse spacing on `pulse_o` = `holdoff_i + 1` cycles, or 2 cycles when `holdoff_i = 0` (an edge needs a low sample in between).
- Input pulses narrower than one clock period may be missed; this is not an error.
- `missed_o` is set 1 cycle after the dropped edge is detected. `pulse_o` is combinationally independent of all inputs (fully registered).

## Structure
- Package `radiant_scaler_pkg`: channel state enum (`ARMED`, `HOLD`), default `HOLDOFF_BITS`/`STUCK_BITS` localparams.
- Sub-module `radiant_scaler_input_ch`: one channel (sync, edge, FSM, holdoff counter, stuck counter, missed flag). The top is a generate loop plus shared `veto_i`/`holdoff_i`/`clear_i` fan-out.
- Synchronizer FFs carry ASYNC_REG attribute.

## Test plan
- Single edge, `holdoff_i = 0`: `trig_i[3]` rises at E0 → `pulse_o[3]` high only the cycle after E2; all other bits 0.
- Holdoff: `holdoff_i = 10`, edges on ch0 at cycles 0, 5, 20 (1-cycle highs) → pulses for edges 0 and 20 only, `missed_o[0] = 1` after edge 5; `clear_i` → 0.
- Veto/mask: `veto_i = 1` during edge on ch1 → no pulse, no miss, next edge 3 cycles later pulses. `mask_i[2] = 1` → ch2 never pulses.
- Stuck: `STUCK_BITS = 4`, hold `trig_i[5]` high 20 cycles → one pulse; `stuck_o[5]` rises 15 cycles after `s2` high, falls 1 cycle after `s2` low.
- Boundaries: edge coincident with HOLD→ARMED → pulse, no miss. Clear coincident with miss → `missed_o` stays 1.
- Async reset asserted mid-HOLD → all outputs 0 immediately. Release with `trig_i` high → exactly one pulse.

Source files
------------

// File: rtl/radiant_scaler_pkg.sv
// Shared types and default widths for the RADIANT scaler input conditioning stage.
package radiant_scaler_pkg;

   typedef enum logic {
      ARMED = 1'b0,
      HOLD  = 1'b1
   } ch_state_e;

   localparam int NUM_CH_DEF       = 32;
   localparam int HOLDOFF_BITS_DEF = 8;
   localparam int STUCK_BITS_DEF   = 16;

endpackage

// File: rtl/radiant_scaler_input_ch.sv
// One conditioning channel: 2-FF sync, rising-edge detect, pulse/holdoff FSM,
// sticky missed-edge flag and stuck-high monitor.
module radiant_scaler_input_ch
   import radiant_scaler_pkg::*;
#(
   parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEF,
   parameter int STUCK_BITS   = STUCK_BITS_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    trig_i,
   input  logic                    mask_i,
   input  logic                    veto_i,
   input  logic [HOLDOFF_BITS-1:0] holdoff_i,
   input  logic                    clear_i,
   output logic                    pulse_o,
   output logic                    missed_o,
   output logic                    stuck_o
);

   (* ASYNC_REG = "TRUE" *) logic r_s1;
   (* ASYNC_REG = "TRUE" *) logic r_s2;
   logic                    r_p;
   ch_state_e               r_state;
   logic [HOLDOFF_BITS-1:0] r_cnt;
   logic [STUCK_BITS-1:0]   r_hcnt;
   logic                    r_pulse;
   logic                    r_missed;

   logic w_edge;
   logic w_live;
   logic w_miss;

   assign w_edge = r_s2 & ~r_p;
   assign w_live = w_edge & ~mask_i & ~veto_i;
   assign w_miss = w_live & (r_state == HOLD);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_p  <= 1'b0;
      end else begin
         r_s1 <= trig_i;
         r_s2 <= r_s1;
         r_p  <= r_s2;
      end
   end

   // A masked channel is parked in ARMED so unmasking never inherits a stale holdoff.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ARMED;
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_pulse <= 1'b0;
         if (mask_i) begin
            r_state <= ARMED;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               ARMED: begin
                  if (w_live) begin
                     r_pulse <= 1'b1;
                     if (holdoff_i != '0) begin
                        r_state <= HOLD;
                        r_cnt   <= holdoff_i;
                     end
                  end
               end
               HOLD: begin
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt <= HOLDOFF_BITS'(1)) begin
                     r_state <= ARMED;
                     r_cnt   <= '0;
                  end
               end
               default: begin
                  r_state <= ARMED;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   // Set takes priority over clear so a miss in the clear cycle is not lost.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         r_missed <= 1'b0;
      else if (w_miss)
         r_missed <= 1'b1;
      else if (clear_i)
         r_missed <= 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         r_hcnt <= '0;
      else if (!r_s2)
         r_hcnt <= '0;
      else if (r_hcnt != '1)
         r_hcnt <= r_hcnt + 1'b1;
   end

   assign pulse_o  = r_pulse;
   assign missed_o = r_missed;
   assign stuck_o  = (r_hcnt == '1);

endmodule

// File: rtl/radiant_scaler_input_cond.sv
// Scaler input conditioning: NUM_CH independent channels sharing veto, holdoff and clear.
module radiant_scaler_input_cond
   import radiant_scaler_pkg::*;
#(
   parameter int NUM_CH       = NUM_CH_DEF,
   parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEF,
   parameter int STUCK_BITS   = STUCK_BITS_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic [NUM_CH-1:0]       trig_i,
   input  logic [NUM_CH-1:0]       mask_i,
   input  logic                    veto_i,
   input  logic [HOLDOFF_BITS-1:0] holdoff_i,
   input  logic                    clear_i,
   output logic [NUM_CH-1:0]       pulse_o,
   output logic [NUM_CH-1:0]       missed_o,
   output logic [NUM_CH-1:0]       stuck_o
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      radiant_scaler_input_ch #(
         .HOLDOFF_BITS (HOLDOFF_BITS),
         .STUCK_BITS   (STUCK_BITS)
      ) u_ch (
         .clk_i     (clk_i),
         .rst_n_i   (rst_n_i),
         .trig_i    (trig_i[g]),
         .mask_i    (mask_i[g]),
         .veto_i    (veto_i),
         .holdoff_i (holdoff_i),
         .clear_i   (clear_i),
         .pulse_o   (pulse_o[g]),
         .missed_o  (missed_o[g]),
         .stuck_o   (stuck_o[g])
      );
   end

endmodule
